// File: rtl/metadata_record_queue_if.sv
// Record stream carrying one queued L2/L3 metadata record per beat.
// METADATA_FRAME_LEN_EN adds the m_frame_len field and LEN_W parameter.
interface metadata_record_queue_if
`ifdef METADATA_FRAME_LEN_EN
#(
   parameter int LEN_W = 16
)
`endif
;
   logic        m_valid;
   logic        m_ready;
   logic [47:0] m_dest_mac;
   logic [47:0] m_src_mac;
   logic [15:0] m_ethertype;
   logic        m_vlan_present;
   logic [11:0] m_vlan_id;
   logic [4:0]  m_l2_len;
   logic [3:0]  m_proto;
   logic        m_no_class;
`ifdef METADATA_FRAME_LEN_EN
   logic [LEN_W-1:0] m_frame_len;
`endif

   modport master (
      output m_valid,
      output m_dest_mac,
      output m_src_mac,
      output m_ethertype,
      output m_vlan_present,
      output m_vlan_id,
      output m_l2_len,
      output m_proto,
      output m_no_class,
`ifdef METADATA_FRAME_LEN_EN
      output m_frame_len,
`endif
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_dest_mac,
      input  m_src_mac,
      input  m_ethertype,
      input  m_vlan_present,
      input  m_vlan_id,
      input  m_l2_len,
      input  m_proto,
      input  m_no_class,
`ifdef METADATA_FRAME_LEN_EN
      input  m_frame_len,
`endif
      output m_ready
   );
endinterface

// File: rtl/metadata_record_queue.sv
// Captures one metadata record per frame and queues it in a DEPTH FIFO.
// Optional macro METADATA_FRAME_LEN_EN adds beat counting (m_frame_len).
module metadata_record_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
`ifdef METADATA_FRAME_LEN_EN
   ,
   parameter int LEN_W = 16
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_start_i,
   input  logic                   frame_end_i,
   input  logic [47:0]            dest_mac_i,
   input  logic [47:0]            src_mac_i,
   input  logic [15:0]            resolved_ethertype_i,
   input  logic                   vlan_present_i,
   input  logic [11:0]            vlan_id_i,
   input  logic [4:0]             l2_header_len_i,
   input  logic                   proto_valid_i,
   input  logic                   is_ipv4_i,
   input  logic                   is_ipv6_i,
   input  logic                   is_arp_i,
   input  logic                   is_unknown_i,
`ifdef METADATA_FRAME_LEN_EN
   input  logic                   beat_valid_i,
`endif
   metadata_record_queue_if.master m_if,
   output logic [$clog2(DEPTH):0] fifo_level_o,
   output logic [CNT_W-1:0]       drop_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [47:0] dest;
      logic [47:0] src;
      logic [15:0] etype;
      logic        vlan_p;
      logic [11:0] vid;
      logic [4:0]  l2_len;
      logic [3:0]  proto;
      logic        no_class;
   } rec_t;

   logic          frame_open_q, frame_open_d;
   logic          captured_q, captured_d;
   logic          pv_q, pv_d;
   rec_t          stg_q;
   rec_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic cap, commit, abort;
   logic full, pop, push, drop_inc;
   rec_t in_rec, push_rec, head;

`ifdef METADATA_FRAME_LEN_EN
   logic [LEN_W-1:0] len_q, len_d, len_sum;
   logic [LEN_W-1:0] len_mem_q [DEPTH];
`endif

   assign cap    = pv_q & frame_open_q & ~captured_q;
   assign commit = frame_end_i & frame_open_q;
   assign abort  = frame_start_i & frame_open_q & ~frame_end_i;
   assign full   = (level_q == LW'(DEPTH));
   assign pop    = (level_q != '0) & m_if.m_ready;
   assign push   = commit & (~full | pop);
   assign drop_inc = abort | (commit & full & ~pop);

   // Assemble the live record and choose what a commit pushes.
   always_comb begin
      in_rec.dest     = dest_mac_i;
      in_rec.src      = src_mac_i;
      in_rec.etype    = resolved_ethertype_i;
      in_rec.vlan_p   = vlan_present_i;
      in_rec.vid      = vlan_id_i;
      in_rec.l2_len   = l2_header_len_i;
      in_rec.proto    = {is_unknown_i, is_arp_i,
                         is_ipv6_i, is_ipv4_i};
      in_rec.no_class = 1'b0;
      push_rec = in_rec;
      if (!cap) begin
         if (captured_q) begin
            push_rec = stg_q;
         end else begin
            push_rec.proto    = 4'b0000;
            push_rec.no_class = 1'b1;
         end
      end
   end

   // Next-state for frame tracking, pointers, level and drops.
   always_comb begin
      frame_open_d = frame_open_q;
      captured_d   = captured_q;
      if (cap) captured_d = 1'b1;
      if (commit) begin
         frame_open_d = 1'b0;
         captured_d   = 1'b0;
      end
      if (frame_start_i) begin
         frame_open_d = 1'b1;
         captured_d   = 1'b0;
      end
      pv_d = proto_valid_i & frame_open_q & ~frame_start_i;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q + {{(LW-1){1'b0}}, push}
                         - {{(LW-1){1'b0}}, pop};
      drop_d   = drop_q;
      if (drop_inc && !(&drop_q)) drop_d = drop_q + 1'b1;
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_open_q <= 1'b0;
         captured_q   <= 1'b0;
         pv_q         <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         drop_q       <= '0;
      end else begin
         frame_open_q <= frame_open_d;
         captured_q   <= captured_d;
         pv_q         <= pv_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         drop_q       <= drop_d;
      end
   end

   // Staging record sampled on the first classification of a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stg_q <= '0;
      else if (cap) stg_q <= in_rec;
   end

   // Record storage; empty slots are masked on the output side.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_rec;
   end

`ifdef METADATA_FRAME_LEN_EN
   assign len_sum = (beat_valid_i && !(&len_q)) ? len_q + 1'b1 : len_q;

   always_comb begin
      len_d = len_q;
      if (frame_open_q) len_d = len_sum;
      if (frame_start_i) len_d = {{(LEN_W-1){1'b0}}, beat_valid_i};
   end

   // Beat counter for the frame currently open.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) len_q <= '0;
      else len_q <= len_d;
   end

   // Length storage alongside each queued record.
   always_ff @(posedge clk) begin
      if (push) len_mem_q[wr_ptr_q] <= len_sum;
   end

   assign m_if.m_frame_len = (level_q != '0) ? len_mem_q[rd_ptr_q] : '0;
`endif

   assign head = (level_q != '0) ? mem_q[rd_ptr_q] : '0;

   assign m_if.m_valid        = (level_q != '0);
   assign m_if.m_dest_mac     = head.dest;
   assign m_if.m_src_mac      = head.src;
   assign m_if.m_ethertype    = head.etype;
   assign m_if.m_vlan_present = head.vlan_p;
   assign m_if.m_vlan_id      = head.vid;
   assign m_if.m_l2_len       = head.l2_len;
   assign m_if.m_proto        = head.proto;
   assign m_if.m_no_class     = head.no_class;
   assign fifo_level_o        = level_q;
   assign drop_cnt_o          = drop_q;

endmodule

// File: tb/tb_metadata_record_queue.sv
// Testbench for metadata_record_queue: vector table plus corner sequences.
// Expected records go to a scoreboard queue and are checked on each pop.
module tb_metadata_record_queue;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic fs, fe, vp, pv, v4, v6, arp, unk, bv;
   logic [47:0] dmac, smac;
   logic [15:0] et;
   logic [11:0] vid;
   logic [4:0]  l2;
   logic [2:0]  lvl;
   logic [15:0] drops;

`ifdef METADATA_FRAME_LEN_EN
   metadata_record_queue_if #(.LEN_W(16)) ifc ();
`else
   metadata_record_queue_if ifc ();
`endif

   metadata_record_queue dut (
      .clk                  (clk),
      .rst                  (rst),
      .frame_start_i        (fs),
      .frame_end_i          (fe),
      .dest_mac_i           (dmac),
      .src_mac_i            (smac),
      .resolved_ethertype_i (et),
      .vlan_present_i       (vp),
      .vlan_id_i            (vid),
      .l2_header_len_i      (l2),
      .proto_valid_i        (pv),
      .is_ipv4_i            (v4),
      .is_ipv6_i            (v6),
      .is_arp_i             (arp),
      .is_unknown_i         (unk),
`ifdef METADATA_FRAME_LEN_EN
      .beat_valid_i         (bv),
`endif
      .m_if                 (ifc),
      .fifo_level_o         (lvl),
      .drop_cnt_o           (drops)
   );

   typedef struct packed {
      logic [47:0] dest;
      logic [47:0] src;
      logic [15:0] et;
      logic        vp;
      logic [11:0] vid;
      logic [4:0]  l2;
      logic [3:0]  proto;
      logic        nc;
      logic [15:0] len;
   } rec_t;

   typedef struct {
      logic [47:0] dest;
      logic [47:0] src;
      logic [15:0] et;
      logic        vp;
      logic [11:0] vid;
      logic [4:0]  l2;
      logic [3:0]  cls;
      bit          pv_end;
      logic [3:0]  exp_proto;
      logic        exp_nc;
   } vec_t;

   rec_t sb[$];
   rec_t mon_got, mon_exp;
   vec_t tbl[5];
   int n_cmp = 0;
   int n_bad = 0;

   function automatic rec_t cur_rec();
      rec_t r;
      r.dest  = ifc.m_dest_mac;
      r.src   = ifc.m_src_mac;
      r.et    = ifc.m_ethertype;
      r.vp    = ifc.m_vlan_present;
      r.vid   = ifc.m_vlan_id;
      r.l2    = ifc.m_l2_len;
      r.proto = ifc.m_proto;
      r.nc    = ifc.m_no_class;
`ifdef METADATA_FRAME_LEN_EN
      r.len   = ifc.m_frame_len;
`else
      r.len   = 16'd0;
`endif
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Pop-side scoreboard: every accepted record is compared in order.
   always @(negedge clk) begin
      if (!rst && ifc.m_valid && ifc.m_ready) begin
         n_cmp++;
         mon_got = cur_rec();
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_record got dest=%0h proto=%0h",
                     mon_got.dest, mon_got.proto);
         end else begin
            mon_exp = sb.pop_front();
            if (mon_got !== mon_exp) begin
               n_bad++;
               $display("FAIL record got dest=%0h src=%0h et=%0h vid=%0h proto=%0h nc=%0b len=%0d exp dest=%0h src=%0h et=%0h vid=%0h proto=%0h nc=%0b len=%0d",
                        mon_got.dest, mon_got.src, mon_got.et,
                        mon_got.vid, mon_got.proto, mon_got.nc,
                        mon_got.len, mon_exp.dest, mon_exp.src,
                        mon_exp.et, mon_exp.vid, mon_exp.proto,
                        mon_exp.nc, mon_exp.len);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Classified frame: start, proto_valid, idle, end (4 beats).
   // No-class frame: start, idle, end+proto_valid (3 beats).
   // Fields change on the end beat to prove the captured copy is used.
   task automatic run_frame(input vec_t v, input bit push_exp,
                            input bit rdy_end);
      rec_t e;
      int n;
      e = '0;
      dmac = v.dest; smac = v.src; et = v.et; vp = v.vp;
      vid = v.vid; l2 = v.l2;
      {unk, arp, v6, v4} = v.cls;
      e.dest = v.dest; e.src = v.src; e.et = v.et; e.vp = v.vp;
      e.vid = v.vid; e.l2 = v.l2;
      e.proto = v.exp_proto; e.nc = v.exp_nc;
      bv = 1'b1; fs = 1'b1; n = 1;
      step();
      fs = 1'b0;
      if (!v.pv_end) begin
         pv = 1'b1; n++;
         step();
         pv = 1'b0; n++;
         step();
         dmac = ~v.dest; smac = ~v.src; fe = 1'b1; n++;
      end else begin
         n++;
         step();
         dmac = ~v.dest; pv = 1'b1; fe = 1'b1; n++;
         e.dest = ~v.dest;
      end
`ifdef METADATA_FRAME_LEN_EN
      e.len = 16'(n);
`endif
      if (push_exp) sb.push_back(e);
      if (rdy_end) ifc.m_ready = 1'b1;
      step();
      fe = 1'b0; pv = 1'b0; bv = 1'b0;
      {unk, arp, v6, v4} = 4'b0000;
      if (rdy_end) ifc.m_ready = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      ifc.m_ready = 1'b1;
      while (sb.size() != 0 && k < 40) begin
         step();
         k++;
      end
      check("drain_done", 64'(sb.size()), 64'd0);
      check("drain_level", 64'(lvl), 64'd0);
   endtask

`ifdef METADATA_FRAME_LEN_EN
   task automatic len_frame(input int n, input logic [47:0] d);
      rec_t e;
      e = '0;
      dmac = d; smac = 48'h1; et = 16'h0800; vp = 1'b0;
      vid = 12'h0; l2 = 5'd14;
      fs = 1'b1; bv = 1'b1;
      step();
      fs = 1'b0;
      repeat (n - 2) step();
      fe = 1'b1;
      e.dest = d; e.src = 48'h1; e.et = 16'h0800; e.l2 = 5'd14;
      e.nc = 1'b1; e.len = 16'(n);
      sb.push_back(e);
      step();
      fe = 1'b0; bv = 1'b0;
   endtask
`endif

   initial begin
      vec_t v;
      logic [15:0] d0;
      logic [47:0] hd;
      rec_t e;

      tbl[0] = '{48'h0011_2233_4455, 48'hA0A1_A2A3_A4A5, 16'h0800,
                 1'b1, 12'h00A, 5'd18, 4'b0001, 1'b0, 4'b0001, 1'b0};
      tbl[1] = '{48'h0200_0000_0001, 48'h0200_0000_0002, 16'h86DD,
                 1'b0, 12'h000, 5'd14, 4'b0010, 1'b0, 4'b0010, 1'b0};
      tbl[2] = '{48'hFFFF_FFFF_FFFF, 48'h0200_0000_0003, 16'h0806,
                 1'b0, 12'h000, 5'd14, 4'b0100, 1'b0, 4'b0100, 1'b0};
      tbl[3] = '{48'h0200_0000_0004, 48'h0200_0000_0005, 16'h88CC,
                 1'b1, 12'hFFF, 5'd31, 4'b1000, 1'b0, 4'b1000, 1'b0};
      tbl[4] = '{48'h0200_0000_0006, 48'h0200_0000_0007, 16'h0800,
                 1'b0, 12'h123, 5'd14, 4'b0001, 1'b1, 4'b0000, 1'b1};

      rst = 1'b1;
      fs = 0; fe = 0; vp = 0; pv = 0; v4 = 0; v6 = 0; arp = 0;
      unk = 0; bv = 0; dmac = '0; smac = '0; et = '0; vid = '0; l2 = '0;
      ifc.m_ready = 1'b0;
      #1;
      check("reset_valid", 64'(ifc.m_valid), 64'd0);
      check("reset_level", 64'(lvl), 64'd0);
      check("reset_drops", 64'(drops), 64'd0);
      check("reset_dest", 64'(ifc.m_dest_mac), 64'd0);
      step();
      rst = 1'b0;
      step();

      // Single ipv4 frame: valid one cycle after end, then drained.
      run_frame(tbl[0], 1'b1, 1'b0);
      check("single_valid", 64'(ifc.m_valid), 64'd1);
      check("single_level", 64'(lvl), 64'd1);
      drain();

      // Table of frames, consumer always ready.
      for (int i = 0; i < 5; i++) run_frame(tbl[i], 1'b1, 1'b0);
      drain();

      // Empty with ready high: no underflow.
      repeat (3) step();
      check("empty_level", 64'(lvl), 64'd0);
      check("empty_valid", 64'(ifc.m_valid), 64'd0);

      // Stray frame_end with no open frame is ignored.
      fe = 1'b1;
      step();
      fe = 1'b0;
      step();
      check("stray_end_level", 64'(lvl), 64'd0);

      // Abort, then end+start on the same cycle, then end.
      d0 = drops;
      fs = 1'b1;
      step();
      fs = 1'b0;
      step();
      fs = 1'b1;
      step();
      fs = 1'b0;
      check("abort_drop", 64'(drops), 64'(d0 + 16'd1));
      e = '0;
      dmac = 48'h0A00_0000_00B1; smac = 48'h0A00_0000_00B2;
      et = 16'h0800; vp = 1'b0; vid = 12'h0; l2 = 5'd14;
      e.dest = dmac; e.src = smac; e.et = et; e.l2 = l2; e.nc = 1'b1;
`ifdef METADATA_FRAME_LEN_EN
      e.len = 16'd1;
`endif
      sb.push_back(e);
      fe = 1'b1; fs = 1'b1; bv = 1'b1;
      step();
      fe = 1'b0; fs = 1'b0;
      step();
      dmac = 48'h0A00_0000_00C1;
      e.dest = dmac;
`ifdef METADATA_FRAME_LEN_EN
      e.len = 16'd3;
`endif
      sb.push_back(e);
      fe = 1'b1;
      step();
      fe = 1'b0; bv = 1'b0;
      drain();
      check("b2b_drop", 64'(drops), 64'(d0 + 16'd1));

      // Backpressure: five commits into four slots.
      ifc.m_ready = 1'b0;
      d0 = drops;
      for (int i = 0; i < 5; i++) begin
         v = tbl[0];
         v.dest = 48'h0B00_0000_0000 + 48'(i);
         run_frame(v, (i < 4), 1'b0);
      end
      check("bp_level", 64'(lvl), 64'd4);
      check("bp_drop", 64'(drops), 64'(d0 + 16'd1));
      repeat (2) step();
      hd = sb[0].dest;
      check("bp_stable", 64'(ifc.m_dest_mac), 64'(hd));

      // Full with a pop on the commit cycle: push succeeds.
      v = tbl[1];
      v.dest = 48'h0B00_0000_0010;
      run_frame(v, 1'b1, 1'b1);
      check("fullpop_level", 64'(lvl), 64'd4);
      check("fullpop_drop", 64'(drops), 64'(d0 + 16'd1));
      drain();

      // Asynchronous reset with two records queued.
      ifc.m_ready = 1'b0;
      run_frame(tbl[2], 1'b1, 1'b0);
      run_frame(tbl[3], 1'b1, 1'b0);
      check("prerst_level", 64'(lvl), 64'd2);
      #2;
      rst = 1'b1;
      #1;
      check("rst_valid", 64'(ifc.m_valid), 64'd0);
      check("rst_level", 64'(lvl), 64'd0);
      check("rst_drops", 64'(drops), 64'd0);
      sb.delete();
      step();
      rst = 1'b0;
      step();

`ifdef METADATA_FRAME_LEN_EN
      // Beat counting: 64 and 60 beats start..end inclusive.
      ifc.m_ready = 1'b1;
      len_frame(64, 48'h0C00_0000_0040);
      len_frame(60, 48'h0C00_0000_003C);
      drain();
`endif

      step();
      check("final_valid", 64'(ifc.m_valid), 64'd0);
      check("final_sb", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
